// File: rtl/systolic_pkg.sv
// Shared state encoding and sizing helpers for the systolic array front end.
package systolic_pkg;

    typedef enum logic [1:0] {
        W_COLLECT,
        W_LOAD,
        STREAM,
        DRAIN
    } state_t;

    localparam int DEF_DATA_WIDTH = 4;
    localparam int DEF_ARRAY_SIZE = 4;

    // Weight load occupies two cycles per row, minus the trailing bubble.
    function automatic int load_len(input int n);
        return 2 * n - 1;
    endfunction

    function automatic int row_width(input int n, input int dw);
        return n * dw;
    endfunction

    function automatic int cnt_width(input int n);
        return (load_len(n) > 1) ? $clog2(load_len(n)) : 1;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/systolic_feeder_skew_line.sv
// Fixed-depth shift register used to stagger one activation row.
module skew_line #(
    parameter int DEPTH      = 1,
    parameter int DATA_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] sr [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                sr[i] <= '0;
            end
        end else begin
            sr[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign dout = sr[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// Weight loader and skewed activation streamer for a weight-stationary array.
//   state     | meaning
//   W_COLLECT | accepting weight rows into the bank
//   W_LOAD    | shifting the bank into the array, load high for 2N-1 cycles
//   STREAM    | accepting activation vectors, bubbles on idle cycles
//   DRAIN     | N cycles of bubbles after the last vector of a batch
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ARRAY_SIZE = DEF_ARRAY_SIZE
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             w_valid,
    output logic                             w_ready,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] w_row,
    input  logic                             a_valid,
    output logic                             a_ready,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] a_row,
    input  logic                             a_last,
    output logic                             load,
    output logic [ARRAY_SIZE*DATA_WIDTH-1:0] pe_weight,
    output logic [ARRAY_SIZE*DATA_WIDTH-1:0] pe_val,
    output logic                             res_valid,
    output logic                             busy
);

    localparam int ROW_W    = row_width(ARRAY_SIZE, DATA_WIDTH);
    localparam int LOAD_LEN = load_len(ARRAY_SIZE);
    localparam int CW       = cnt_width(ARRAY_SIZE);
    localparam int HW       = CW - 1;
    localparam int RW       = idx_width(ARRAY_SIZE);

    state_t            state, state_nx;
    logic [RW-1:0]     rcnt, rcnt_nx;
    logic [CW-1:0]     tmr, tmr_nx;
    logic [ROW_W-1:0]  bank [ARRAY_SIZE];
    logic              load_nx, w_ready_nx, a_ready_nx, busy_nx;
    logic [ROW_W-1:0]  wt_nx;
    logic              w_fire, a_fire;
    logic [ROW_W-1:0]  skew_in;
    logic [ARRAY_SIZE:0] rv_pipe;

    assign w_fire = w_valid && w_ready;
    assign a_fire = a_valid && a_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= W_COLLECT;
            rcnt  <= '0;
            tmr   <= '0;
        end else begin
            state <= state_nx;
            rcnt  <= rcnt_nx;
            tmr   <= tmr_nx;
        end
    end

    always_comb begin
        state_nx = state;
        rcnt_nx  = rcnt;
        tmr_nx   = tmr;
        unique case (state)
            W_COLLECT: begin
                if (w_fire) begin
                    if (rcnt == RW'(ARRAY_SIZE - 1)) begin
                        state_nx = W_LOAD;
                        rcnt_nx  = '0;
                        tmr_nx   = CW'(LOAD_LEN - 1);
                    end else begin
                        rcnt_nx = rcnt + 1'b1;
                    end
                end
            end
            W_LOAD: begin
                if (tmr == '0) begin
                    state_nx = STREAM;
                end else begin
                    tmr_nx = tmr - 1'b1;
                end
            end
            STREAM: begin
                if (a_fire && a_last) begin
                    state_nx = DRAIN;
                    tmr_nx   = CW'(ARRAY_SIZE - 1);
                end
            end
            DRAIN: begin
                if (tmr == '0) begin
                    state_nx = W_COLLECT;
                end else begin
                    tmr_nx = tmr - 1'b1;
                end
            end
            default: state_nx = W_COLLECT;
        endcase

        load_nx    = (state_nx == W_LOAD);
        w_ready_nx = (state_nx == W_COLLECT);
        a_ready_nx = (state_nx == STREAM);
        busy_nx    = !((state_nx == W_COLLECT) && (rcnt_nx == '0));

        // Remaining-cycle count m: even m carries bank[m/2], odd m is a bubble.
        // The first load cycle needs the row being accepted right now.
        wt_nx = '0;
        if ((state_nx == W_LOAD) && !tmr_nx[0]) begin
            if (state == W_COLLECT) begin
                wt_nx = w_row;
            end else begin
                for (int i = 0; i < ARRAY_SIZE; i++) begin
                    if (tmr_nx[CW-1:1] == HW'(i)) begin
                        wt_nx = bank[i];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load      <= 1'b0;
            w_ready   <= 1'b0;
            a_ready   <= 1'b0;
            busy      <= 1'b0;
            pe_weight <= '0;
            for (int i = 0; i < ARRAY_SIZE; i++) begin
                bank[i] <= '0;
            end
        end else begin
            load      <= load_nx;
            w_ready   <= w_ready_nx;
            a_ready   <= a_ready_nx;
            busy      <= busy_nx;
            pe_weight <= wt_nx;
            if (w_fire) begin
                bank[rcnt] <= w_row;
            end
        end
    end

    // Issue flop plus the N-stage column latency of the array.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rv_pipe <= '0;
        end else begin
            rv_pipe <= {rv_pipe[ARRAY_SIZE-1:0], a_fire};
        end
    end

    assign res_valid = rv_pipe[ARRAY_SIZE];
    assign skew_in   = a_fire ? a_row : '0;

    for (genvar r = 0; r < ARRAY_SIZE; r++) begin : g_skew
        skew_line #(
            .DEPTH      (r + 1),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_skew (
            .clk   (clk),
            .reset (reset),
            .din   (skew_in[r*DATA_WIDTH +: DATA_WIDTH]),
            .dout  (pe_val[r*DATA_WIDTH +: DATA_WIDTH])
        );
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// Randomized bench for systolic_feeder against a cycle-scheduled behavioural model.
module tb_systolic_feeder;

    localparam int N    = 4;
    localparam int DW   = 4;
    localparam int MAXC = 2048;

    localparam int PH_PRE = 0;
    localparam int PH_COL = 1;
    localparam int PH_LD  = 2;
    localparam int PH_ST  = 3;
    localparam int PH_DR  = 4;

    logic          clk;
    logic          reset;
    logic          w_valid, w_ready;
    logic [15:0]   w_row;
    logic          a_valid, a_ready;
    logic [15:0]   a_row;
    logic          a_last;
    logic          load;
    logic [15:0]   pe_weight, pe_val;
    logic          res_valid, busy;

    systolic_feeder #(.DATA_WIDTH(DW), .ARRAY_SIZE(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_row     (w_row),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_row     (a_row),
        .a_last    (a_last),
        .load      (load),
        .pe_weight (pe_weight),
        .pe_val    (pe_val),
        .res_valid (res_valid),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected outputs per cycle; val/rv are scheduled ahead on each accept.
    bit          exp_load [MAXC];
    bit          exp_wr   [MAXC];
    bit          exp_ar   [MAXC];
    bit          exp_busy [MAXC];
    bit          exp_rv   [MAXC];
    logic [15:0] exp_wt   [MAXC];
    logic [15:0] exp_val  [MAXC];

    int ph   = PH_PRE;
    int k    = 0;
    int rows = 0;
    logic [15:0] mw [N];
    logic [15:0] vq [$];

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on && cyc < MAXC) begin
            check_eq("load",      32'(load),      32'(exp_load[cyc]));
            check_eq("pe_weight", 32'(pe_weight), 32'(exp_wt[cyc]));
            check_eq("pe_val",    32'(pe_val),    32'(exp_val[cyc]));
            check_eq("res_valid", 32'(res_valid), 32'(exp_rv[cyc]));
            check_eq("w_ready",   32'(w_ready),   32'(exp_wr[cyc]));
            check_eq("a_ready",   32'(a_ready),   32'(exp_ar[cyc]));
            check_eq("busy",      32'(busy),      32'(exp_busy[cyc]));
        end
    end

    function automatic logic [15:0] pack(input int a0, input int a1, input int a2, input int a3);
        logic [3:0] e [4];
        e[0] = 4'(a0);
        e[1] = 4'(a1);
        e[2] = 4'(a2);
        e[3] = 4'(a3);
        return {e[3], e[2], e[1], e[0]};
    endfunction

    // One clock of stimulus; the model predicts this cycle's outputs and
    // what the coming edge transfers, from the handshake and timing rules.
    task automatic tick(input bit rst_i, input bit wv, input logic [15:0] wr_i,
                        input bit av, input logic [15:0] ar_i, input bit al);
        int n;
        @(posedge clk);
        #2;
        n = cyc;
        reset   = rst_i;
        w_valid = wv;
        w_row   = wr_i;
        a_valid = av;
        a_row   = ar_i;
        a_last  = al;
        if (rst_i) begin
            for (int t = n; t < MAXC; t++) begin
                exp_val[t] = '0;
                exp_rv[t]  = 1'b0;
            end
            exp_load[n] = 1'b0;
            exp_wt[n]   = '0;
            exp_wr[n]   = 1'b0;
            exp_ar[n]   = 1'b0;
            exp_busy[n] = 1'b0;
            ph   = PH_PRE;
            rows = 0;
            return;
        end
        exp_load[n] = (ph == PH_LD);
        exp_wt[n]   = ((ph == PH_LD) && (k % 2 == 0)) ? mw[N - 1 - k / 2] : 16'h0;
        exp_wr[n]   = (ph == PH_COL);
        exp_ar[n]   = (ph == PH_ST);
        exp_busy[n] = (ph == PH_COL) ? (rows != 0) : (ph != PH_PRE);
        case (ph)
            PH_PRE: begin
                ph   = PH_COL;
                rows = 0;
            end
            PH_COL: begin
                if (wv) begin
                    mw[rows] = wr_i;
                    rows++;
                    if (rows == N) begin
                        ph   = PH_LD;
                        k    = 0;
                        rows = 0;
                    end
                end
            end
            PH_LD: begin
                k++;
                if (k == 2 * N - 1) ph = PH_ST;
            end
            PH_ST: begin
                if (av) begin
                    for (int r = 0; r < N; r++) begin
                        if (n + 1 + r < MAXC) exp_val[n + 1 + r][r*DW +: DW] = ar_i[r*DW +: DW];
                    end
                    if (n + 1 + N < MAXC) exp_rv[n + 1 + N] = 1'b1;
                    if (al) begin
                        ph = PH_DR;
                        k  = 0;
                    end
                end
            end
            default: begin
                k++;
                if (k == N) begin
                    ph   = PH_COL;
                    rows = 0;
                end
            end
        endcase
    endtask

    task automatic load_weights(input logic [15:0] w [N], input bit dense);
        int  guard;
        bit  v;
        guard = 0;
        while (ph != PH_LD && guard < 200) begin
            v = dense ? 1'b1 : ($urandom_range(0, 3) != 0);
            tick(1'b0, v, v ? w[rows] : 16'($urandom), 1'($urandom_range(0, 1)), 16'($urandom), 1'b0);
            guard++;
        end
    endtask

    task automatic finish_load();
        while (ph == PH_LD) tick(1'b0, 1'b1, 16'($urandom), 1'b1, 16'($urandom), 1'b0);
    endtask

    task automatic stream(input bit rnd_gaps, input int gap_before);
        int i;
        int guard;
        bit gapped;
        bit gap;
        i = 0;
        guard = 0;
        gapped = 1'b0;
        while (ph == PH_ST && guard < 400 && i < vq.size()) begin
            if (rnd_gaps) gap = ($urandom_range(0, 2) == 0);
            else          gap = (i == gap_before) && !gapped;
            if (gap) begin
                gapped = 1'b1;
                tick(1'b0, 1'b1, 16'($urandom), 1'b0, 16'($urandom), 1'b1);
            end else begin
                tick(1'b0, 1'b1, 16'($urandom), 1'b1, vq[i], i == vq.size() - 1);
                i++;
            end
            guard++;
        end
        while (ph == PH_DR) tick(1'b0, 1'b1, 16'($urandom), 1'b1, 16'($urandom), 1'b1);
    endtask

    task automatic idle(input int cnt);
        repeat (cnt) tick(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic session(input logic [15:0] w [N], input bit dense, input bit rnd_gaps, input int gap_before);
        load_weights(w, dense);
        finish_load();
        stream(rnd_gaps, gap_before);
    endtask

    logic [15:0] wa [N];
    int nv;

    initial begin
        reset   = 1'b1;
        w_valid = 1'b0;
        w_row   = '0;
        a_valid = 1'b0;
        a_row   = '0;
        a_last  = 1'b0;
        for (int t = 0; t < MAXC; t++) begin
            exp_load[t] = 0; exp_wr[t] = 0; exp_ar[t] = 0; exp_busy[t] = 0;
            exp_rv[t] = 0; exp_wt[t] = '0; exp_val[t] = '0;
        end

        tick(1'b1, 1'b1, 16'hffff, 1'b1, 16'hffff, 1'b0);
        chk_on = 1'b1;
        tick(1'b1, 1'b1, 16'hffff, 1'b1, 16'hffff, 1'b0);
        tick(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);

        // W[r][c] = r*4+c-8; three back-to-back vectors, a gap, then the last.
        for (int r = 0; r < N; r++) wa[r] = pack(r*4 - 8, r*4 - 7, r*4 - 6, r*4 - 5);
        vq = {};
        vq.push_back(pack(1, 2, 3, 4));
        vq.push_back(pack(-1, -2, -3, -4));
        vq.push_back(pack(7, -8, 5, -6));
        vq.push_back(pack(2, 0, -2, 1));
        session(wa, 1'b1, 1'b0, 3);
        idle(2);

        // Identity weights with x = (1,-2,3,-4).
        for (int r = 0; r < N; r++) wa[r] = pack(r == 0, r == 1, r == 2, r == 3);
        vq = {};
        vq.push_back(pack(1, -2, 3, -4));
        session(wa, 1'b0, 1'b0, -1);

        // Signed extremes.
        for (int r = 0; r < N; r++) wa[r] = pack(-8, -8, -8, -8);
        vq = {};
        vq.push_back(pack(-8, -8, -8, -8));
        vq.push_back(pack(-8, -8, -8, -8));
        session(wa, 1'b1, 1'b0, -1);

        // Reset in load cycle 3, then a full fresh session.
        for (int r = 0; r < N; r++) wa[r] = 16'($urandom);
        load_weights(wa, 1'b0);
        while (ph == PH_LD && k < 3) tick(1'b0, 1'b1, 16'($urandom), 1'b1, 16'($urandom), 1'b0);
        tick(1'b1, 1'b1, 16'($urandom), 1'b1, 16'($urandom), 1'b0);
        tick(1'b1, 1'b1, 16'($urandom), 1'b1, 16'($urandom), 1'b0);
        for (int r = 0; r < N; r++) wa[r] = 16'($urandom);
        vq = {};
        for (int i = 0; i < 3; i++) vq.push_back(16'($urandom));
        session(wa, 1'b0, 1'b1, -1);

        // Random sessions, one with a reset in the middle of streaming.
        for (int s = 0; s < 6; s++) begin
            for (int r = 0; r < N; r++) wa[r] = 16'($urandom);
            vq = {};
            nv = $urandom_range(1, 6);
            for (int i = 0; i < nv; i++) vq.push_back(16'($urandom));
            if (s == 3) begin
                load_weights(wa, 1'b1);
                finish_load();
                tick(1'b0, 1'b0, 16'h0, 1'b1, 16'($urandom), 1'b0);
                tick(1'b0, 1'b0, 16'h0, 1'b1, 16'($urandom), 1'b0);
                tick(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
            end else begin
                session(wa, 1'($urandom_range(0, 1)), 1'b1, -1);
                idle($urandom_range(0, 3));
            end
        end

        idle(N + 3);
        @(negedge clk);
        #1;
        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
